// File: rtl/timer_mst_pkg.sv
// timer_mst_pkg: shared types and constants for the timer register master.
// Holds command opcodes, FSM state codes, register map and timer mode codes.
package timer_mst_pkg;

    typedef enum logic [2:0] {
        OP_WRITE = 3'd0,
        OP_READ  = 3'd1,
        OP_POLL  = 3'd2,
        OP_START = 3'd3,
        OP_STOP  = 3'd4
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ACCESS    = 3'd1;
    localparam state_t ST_POLL_RD   = 3'd2;
    localparam state_t ST_POLL_WAIT = 3'd3;
    localparam state_t ST_RESP      = 3'd4;

    localparam logic [1:0] ADDR_COUNT  = 2'd0;
    localparam logic [1:0] ADDR_MODE   = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [2:0] MODE_IDLE     = 3'd0;
    localparam logic [2:0] MODE_UP       = 3'd1;
    localparam logic [2:0] MODE_DOWN     = 3'd2;
    localparam logic [2:0] MODE_FREE_RUN = 3'd3;
    localparam logic [2:0] MODE_PERIODIC = 3'd4;
    localparam logic [2:0] MODE_UP_DOWN  = 3'd5;

endpackage

// File: rtl/timer_mst_pacer.sv
// timer_mst_pacer: gap down-counter between status reads plus the
// saturating poll counter and its limit compare (TIMER_MST_TIMEOUT_EN).
module timer_mst_pacer #(
    parameter int CW        = 32,
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          bump,
    input  logic          gap_load,
    input  logic          gap_tick,
    output logic          gap_done,
    output logic [CW-1:0] polls_next,
    output logic          timeout
);

    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(POLL_GAP - 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_POLLS);

`ifdef TIMER_MST_TIMEOUT_EN
    localparam logic TMO_EN = 1'b1;
`else
    localparam logic TMO_EN = 1'b0;
`endif

    logic [GW-1:0] gap_q;
    logic [CW-1:0] polls_q;

    assign gap_done   = (gap_q == '0);
    assign polls_next = (&polls_q) ? polls_q : polls_q + 1'b1;
    assign timeout    = TMO_EN & (polls_next == LIMIT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q   <= '0;
            polls_q <= '0;
        end else begin
            if (gap_load)
                gap_q <= GAP_INIT;
            else if (gap_tick && !gap_done)
                gap_q <= gap_q - 1'b1;

            if (clear)
                polls_q <= '0;
            else if (bump)
                polls_q <= polls_next;
        end
    end

endmodule

// File: rtl/timer_reg_master.sv
// timer_reg_master: turns queued commands into timer register bus cycles.
// Optional poll timeout after MAX_POLLS reads: define TIMER_MST_TIMEOUT_EN.
module timer_reg_master
    import timer_mst_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int POLL_GAP      = 4,
    parameter int MAX_POLLS     = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [1:0]               cmd_addr,
    input  logic [COUNTER_WIDTH-1:0] cmd_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [COUNTER_WIDTH-1:0] resp_data,
    output logic                     resp_err,
    output logic                     en,
    output logic [1:0]               Addr,
    output logic                     we,
    output logic                     re,
    output logic [COUNTER_WIDTH-1:0] load,
    output logic [1:0]               size,
    input  logic [COUNTER_WIDTH-1:0] counter_value,
    input  logic                     check
);

    localparam int CW = COUNTER_WIDTH;

    state_t        state_q;
    logic          run_q;
    logic [1:0]    addr_q;
    logic [CW-1:0] data_q;
    logic          wr_q;
    logic [CW-1:0] rdata_q;
    logic          rerr_q;

    logic          gap_done;
    logic          timeout;
    logic [CW-1:0] polls_next;

    timer_mst_pacer #(
        .CW        (CW),
        .POLL_GAP  (POLL_GAP),
        .MAX_POLLS (MAX_POLLS)
    ) u_pacer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q == ST_IDLE),
        .bump       (state_q == ST_POLL_RD),
        .gap_load   (state_q == ST_POLL_RD),
        .gap_tick   (state_q == ST_POLL_WAIT),
        .gap_done   (gap_done),
        .polls_next (polls_next),
        .timeout    (timeout)
    );

    assign cmd_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = rdata_q;
    assign resp_err   = rerr_q;
    assign size       = SIZE_WORD;

    assign en = run_q
              | (state_q == ST_ACCESS)
              | (state_q == ST_POLL_RD)
              | (state_q == ST_POLL_WAIT);

    always_comb begin
        Addr = '0;
        we   = 1'b0;
        re   = 1'b0;
        load = '0;
        case (state_q)
            ST_ACCESS: begin
                Addr = addr_q;
                we   = wr_q;
                re   = !wr_q;
                load = wr_q ? data_q : '0;
            end
            ST_POLL_RD: begin
                Addr = ADDR_STATUS;
                re   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        data_q  <= cmd_data;
                        wr_q    <= (cmd_op == OP_WRITE);
                        rdata_q <= '0;
                        rerr_q  <= 1'b0;
                        case (cmd_op)
                            OP_WRITE,
                            OP_READ:  state_q <= ST_ACCESS;
                            OP_POLL:  state_q <= ST_POLL_RD;
                            OP_START: begin
                                run_q   <= 1'b1;
                                state_q <= ST_RESP;
                            end
                            OP_STOP: begin
                                run_q   <= 1'b0;
                                state_q <= ST_RESP;
                            end
                            default: begin
                                rerr_q  <= 1'b1;
                                state_q <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ACCESS: begin
                    if (wr_q)
                        rerr_q <= check;
                    else
                        rdata_q <= counter_value;
                    state_q <= ST_RESP;
                end
                ST_POLL_RD: begin
                    // finish wins over a timeout reached on the same read
                    if (counter_value[0]) begin
                        rdata_q <= polls_next;
                        state_q <= ST_RESP;
                    end else if (timeout) begin
                        rdata_q <= polls_next;
                        rerr_q  <= 1'b1;
                        state_q <= ST_RESP;
                    end else begin
                        state_q <= ST_POLL_WAIT;
                    end
                end
                ST_POLL_WAIT: begin
                    if (gap_done)
                        state_q <= ST_POLL_RD;
                end
                ST_RESP: begin
                    if (resp_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
